// File: rtl/div_pkg.sv
// +----------------------------------------------------------------------+
// | div_pkg                                                              |
// | Shared types, width helper and special-case result constants for the |
// | iterative divider.                                                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  // Unit sequencing: waiting for work, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Width of the remaining-iteration counter; it must be able to hold XLEN itself.
  function automatic int cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

  // Divide-by-zero quotient is all ones; signed-overflow remainder is all zeros.
  // Stored as fill bits so every XLEN can replicate them.
  localparam bit DIV0_QUOT_BIT = 1'b1;
  localparam bit OVF_REM_BIT   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/div_iter_unit_if.sv
// +----------------------------------------------------------------------+
// | div_iter_unit_if                                                     |
// | Request/response handshake bundle for the iterative divider,         |
// | including the pipeline flush.                                        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

interface div_iter_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;
  logic             out_valid;
  logic [XLEN-1:0]  out_quot;
  logic [XLEN-1:0]  out_rem;
  logic [TAG_W-1:0] out_tag;

  // Divider side.
  modport slave (
    input  flush, in_valid, in_sign, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_tag
  );

  // Issuing/consuming side.
  modport master (
    output flush, in_valid, in_sign, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_tag
  );

endinterface

`default_nettype wire

// File: rtl/div_fixup.sv
// +----------------------------------------------------------------------+
// | div_fixup                                                            |
// | Conditional two's-complement negate, used both to take operand       |
// | magnitudes and to restore result signs.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module div_fixup #(
  parameter int XLEN = 32
) (
  input  logic            neg_i,
  input  logic [XLEN-1:0] val_i,
  output logic [XLEN-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + XLEN'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/div_iter_unit.sv
// +----------------------------------------------------------------------+
// | div_iter_unit                                                        |
// | Radix-2 restoring divider, one quotient bit per cycle, signed or     |
// | unsigned, with tag pass-through, flush and one-cycle special cases.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module div_iter_unit
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  div_iter_unit_if.slave bus_if
);

  localparam int              CW        = cnt_w(XLEN);
  localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{DIV0_QUOT_BIT}};
  localparam logic [XLEN-1:0] OVF_REM   = {XLEN{OVF_REM_BIT}};
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  prem_q, prem_d;    // partial remainder
  logic [XLEN-1:0]  dvd_q, dvd_d;      // dividend in, quotient bits shift in at the LSB
  logic [XLEN-1:0]  dvs_q, dvs_d;      // divisor magnitude
  logic             qs_q, qs_d;
  logic             rs_q, rs_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic             rdy, accept, is_div0, is_ovf, last_iter;
  logic [XLEN-1:0]  a_mag, b_mag, q_fix, r_fix, q_step, r_step;
  logic [XLEN:0]    shifted, trial;
  logic             qbit;

  div_fixup #(.XLEN(XLEN)) u_fix_a (
    .neg_i (bus_if.in_sign & bus_if.in_a[XLEN-1]),
    .val_i (bus_if.in_a),
    .val_o (a_mag)
  );

  div_fixup #(.XLEN(XLEN)) u_fix_b (
    .neg_i (bus_if.in_sign & bus_if.in_b[XLEN-1]),
    .val_i (bus_if.in_b),
    .val_o (b_mag)
  );

  div_fixup #(.XLEN(XLEN)) u_fix_q (
    .neg_i (qs_q),
    .val_i (q_step),
    .val_o (q_fix)
  );

  div_fixup #(.XLEN(XLEN)) u_fix_r (
    .neg_i (rs_q),
    .val_i (r_step),
    .val_o (r_fix)
  );

  assign is_div0   = (bus_if.in_b == '0);
  assign is_ovf    = bus_if.in_sign & (bus_if.in_a == INT_MIN) & (bus_if.in_b == '1);
  assign last_iter = (cnt_q == CW'(1));

  // One restoring step: bring in the next dividend bit, keep the trial difference if it did not go negative.
  always_comb begin
    shifted = {prem_q, dvd_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[XLEN];
    r_step  = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    q_step  = {dvd_q[XLEN-2:0], qbit};
  end

  // Handshake and next-state selection; flush overrides everything, a dropped accept included.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    case (state_q)
      IDLE:    rdy = 1'b1;
      DONE:    rdy = bus_if.out_ready;
      default: rdy = 1'b0;
    endcase
    accept = bus_if.in_valid & rdy & ~bus_if.flush;
    case (state_q)
      IDLE:    state_d = IDLE;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    if (bus_if.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) state_d = (is_div0 | is_ovf) ? DONE : BUSY;
    if (bus_if.flush) state_d = IDLE;
  end

  // Datapath next values: iterate while busy, load operands or special-case results on accept.
  always_comb begin
    cnt_d  = cnt_q;
    prem_d = prem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    qs_d   = qs_q;
    rs_d   = rs_q;
    tag_d  = tag_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    otag_d = otag_q;
    if (state_q == BUSY) begin
      prem_d = r_step;
      dvd_d  = q_step;
      cnt_d  = cnt_q - CW'(1);
      if (last_iter && !bus_if.flush) begin
        quot_d = q_fix;
        rem_d  = r_fix;
        otag_d = tag_q;
      end
    end
    if (accept) begin
      dvd_d  = a_mag;
      dvs_d  = b_mag;
      prem_d = '0;
      cnt_d  = CW'(XLEN);
      qs_d   = bus_if.in_sign & (bus_if.in_a[XLEN-1] ^ bus_if.in_b[XLEN-1]);
      rs_d   = bus_if.in_sign & bus_if.in_a[XLEN-1];
      tag_d  = bus_if.in_tag;
      if (is_div0) begin
        quot_d = DIV0_QUOT;
        rem_d  = bus_if.in_a;
        otag_d = bus_if.in_tag;
      end else if (is_ovf) begin
        quot_d = bus_if.in_a;
        rem_d  = OVF_REM;
        otag_d = bus_if.in_tag;
      end
    end
  end

  // State, iteration and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      tag_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      tag_q   <= tag_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      otag_q  <= otag_d;
    end
  end

  assign bus_if.in_ready  = rdy;
  assign bus_if.out_valid = (state_q == DONE);
  assign bus_if.out_quot  = quot_q;
  assign bus_if.out_rem   = rem_q;
  assign bus_if.out_tag   = otag_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_unit.sv
// +----------------------------------------------------------------------+
// | tb_div_iter_unit                                                     |
// | Scoreboard bench for div_iter_unit at XLEN=32 and XLEN=8.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_div_iter_unit;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  bit     rand_rdy = 1'b0;

  typedef struct {
    longint q;
    longint r;
    longint tag;
    longint cyc;
  } exp_t;

  exp_t   sb32[$];
  exp_t   sb8[$];
  bit     seen32 = 1'b0;
  bit     seen8 = 1'b0;
  longint retire32 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_iter_unit_if #(.XLEN(32), .TAG_W(5)) b32 ();
  div_iter_unit_if #(.XLEN(8),  .TAG_W(5)) b8 ();

  div_iter_unit #(.XLEN(32), .TAG_W(5)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus_if(b32));
  div_iter_unit #(.XLEN(8),  .TAG_W(5)) u_dut8  (.clk_i(clk), .rst_i(rst), .bus_if(b8));

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference divide from the architectural rules, using wide signed arithmetic.
  function automatic void ref_div(input int w, input bit sg, input longint a, input longint b,
                                  output longint q, output longint r, output bit fast);
    longint mask, half, sa, sb;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = a;
    sb   = b;
    fast = 1'b0;
    if (b == 0) begin
      q = mask; r = a; fast = 1'b1;
      return;
    end
    if (sg && a >= half) sa = a - (mask + 1);
    if (sg && b >= half) sb = b - (mask + 1);
    if (sg && sa == -half && sb == -1) begin
      q = a; r = 0; fast = 1'b1;
      return;
    end
    q = (sa / sb) & mask;
    r = (sa % sb) & mask;
  endfunction

  task automatic push32(input longint q, input longint r, input longint tag, input longint c);
    exp_t e;
    e.q = q; e.r = r; e.tag = tag; e.cyc = c;
    sb32.push_back(e);
  endtask

  task automatic push8(input longint q, input longint r, input longint tag, input longint c);
    exp_t e;
    e.q = q; e.r = r; e.tag = tag; e.cyc = c;
    sb8.push_back(e);
  endtask

  // Monitor for the 32-bit unit: first-valid latency, values held every valid cycle, pop on retire.
  always @(negedge clk) begin
    if (rst) begin
      seen32 = 1'b0;
    end else if (b32.out_valid) begin
      if (sb32.size() == 0) begin
        chk("unexpected_out32", longint'(b32.out_valid), 0);
      end else begin
        if (!seen32) begin
          seen32 = 1'b1;
          chk("latency32", cyc, sb32[0].cyc);
        end
        chk("quot32", longint'(b32.out_quot), sb32[0].q);
        chk("rem32", longint'(b32.out_rem), sb32[0].r);
        chk("tag32", longint'(b32.out_tag), sb32[0].tag);
        if (b32.out_ready) begin
          void'(sb32.pop_front());
          seen32   = 1'b0;
          retire32 = cyc;
        end
      end
    end
  end

  // Monitor for the 8-bit unit.
  always @(negedge clk) begin
    if (rst) begin
      seen8 = 1'b0;
    end else if (b8.out_valid) begin
      if (sb8.size() == 0) begin
        chk("unexpected_out8", longint'(b8.out_valid), 0);
      end else begin
        if (!seen8) begin
          seen8 = 1'b1;
          chk("latency8", cyc, sb8[0].cyc);
        end
        chk("quot8", longint'(b8.out_quot), sb8[0].q);
        chk("rem8", longint'(b8.out_rem), sb8[0].r);
        chk("tag8", longint'(b8.out_tag), sb8[0].tag);
        if (b8.out_ready) begin
          void'(sb8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) b32.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present a request and hold it until accepted; returns the accept cycle.
  task automatic send32(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit use_ref, output longint t_acc);
    int     budget;
    bit     ok, fast;
    longint q, r;
    budget = 0;
    ok     = 1'b0;
    b32.in_valid = 1'b1;
    b32.in_sign  = sg;
    b32.in_a     = a;
    b32.in_b     = b;
    b32.in_tag   = tag;
    while (!ok && budget < 300) begin
      @(negedge clk);
      if (b32.in_ready) ok = 1'b1;
      else begin
        budget++;
        tick();
      end
    end
    t_acc = cyc;
    if (!ok) chk("accept_timeout32", longint'(b32.in_ready), 1);
    else if (use_ref) begin
      ref_div(32, sg, longint'(a), longint'(b), q, r, fast);
      push32(q, r, longint'(tag), cyc + (fast ? 1 : 33));
    end
    tick();
    b32.in_valid = 1'b0;
  endtask

  task automatic send8(input bit sg, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] tag, input bit use_ref, output longint t_acc);
    int     budget;
    bit     ok, fast;
    longint q, r;
    budget = 0;
    ok     = 1'b0;
    b8.in_valid = 1'b1;
    b8.in_sign  = sg;
    b8.in_a     = a;
    b8.in_b     = b;
    b8.in_tag   = tag;
    while (!ok && budget < 100) begin
      @(negedge clk);
      if (b8.in_ready) ok = 1'b1;
      else begin
        budget++;
        tick();
      end
    end
    t_acc = cyc;
    if (!ok) chk("accept_timeout8", longint'(b8.in_ready), 1);
    else if (use_ref) begin
      ref_div(8, sg, longint'(a), longint'(b), q, r, fast);
      push8(q, r, longint'(tag), cyc + (fast ? 1 : 9));
    end
    tick();
    b8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain32", longint'(sb32.size()), 0);
    chk("drain8", longint'(sb8.size()), 0);
  endtask

  // Stimulus sequence.
  initial begin
    longint      t, t2;
    logic [31:0] ra, rb;
    logic [7:0]  a8, b8v;
    bit          sg;
    int          n;

    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_sign = 1'b0;
    b32.in_a = '0; b32.in_b = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b8.flush = 1'b0; b8.in_valid = 1'b0; b8.in_sign = 1'b0;
    b8.in_a = '0; b8.in_b = '0; b8.in_tag = '0; b8.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", longint'(b32.in_ready), 1);
    chk("rst_out_valid", longint'(b32.out_valid), 0);
    chk("rst_quot", longint'(b32.out_quot), 0);
    chk("rst_rem", longint'(b32.out_rem), 0);
    chk("rst_tag", longint'(b32.out_tag), 0);
    tick();

    // Directed values and latencies with the consumer always ready.
    send32(1'b0, 32'd100, 32'd7, 5'd3, 1'b0, t);                push32(14, 2, 3, t + 33);
    send32(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0, t);          push32(32'hFFFF_FFFD, 32'hFFFF_FFFF, 4, t + 33);
    send32(1'b1, 32'd7, 32'hFFFF_FFFE, 5'd5, 1'b0, t);          push32(32'hFFFF_FFFD, 1, 5, t + 33);
    send32(1'b1, 32'd5, 32'd0, 5'd6, 1'b0, t);                  push32(32'hFFFF_FFFF, 5, 6, t + 1);
    send32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0, t);  push32(32'h8000_0000, 0, 7, t + 1);
    send32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0, t);  push32(0, 32'h8000_0000, 8, t + 33);
    drain();

    // Backpressure: result held with in_ready low, then retire and accept together.
    b32.out_ready = 1'b0;
    send32(1'b1, 32'd5, 32'd0, 5'd9, 1'b0, t);
    push32(32'hFFFF_FFFF, 5, 9, t + 1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(b32.in_ready), 0);
      chk("bp_out_valid", longint'(b32.out_valid), 1);
      tick();
    end
    b32.out_ready = 1'b1;
    send32(1'b0, 32'd100, 32'd7, 5'd10, 1'b0, t2);
    push32(14, 2, 10, t2 + 33);
    chk("retire_accept_same_cycle", retire32, t2);
    drain();

    // Flush of an op in flight: no result, ready again next cycle.
    send32(1'b0, 32'd1000, 32'd3, 5'd11, 1'b0, t);
    while (cyc < t + 10) tick();
    b32.flush = 1'b1;
    tick();
    b32.flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", longint'(b32.in_ready), 1);
    chk("flush_out_valid", longint'(b32.out_valid), 0);
    repeat (40) tick();

    // Flush coincident with a handshake: the (one-cycle) op must vanish.
    b32.in_valid = 1'b1; b32.in_sign = 1'b0; b32.in_a = 32'd5; b32.in_b = 32'd0;
    b32.in_tag = 5'd12; b32.flush = 1'b1;
    tick();
    b32.in_valid = 1'b0; b32.flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_out_valid", longint'(b32.out_valid), 0);
    chk("flush_accept_in_ready", longint'(b32.in_ready), 1);
    repeat (3) tick();

    // Randomised traffic with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 100));
        default: ra = 32'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        3:       rb = 32'd0 - 32'($urandom_range(1, 9));
        default: rb = 32'($urandom) >> $urandom_range(0, 31);
      endcase
      send32(sg, ra, rb, 5'($urandom), 1'b1, t);
    end
    drain();
    rand_rdy = 1'b0;
    b32.out_ready = 1'b1;

    // Reset in the middle of an iteration, after a non-zero result was left in the outputs.
    send32(1'b0, 32'd100, 32'd7, 5'd3, 1'b0, t);
    push32(14, 2, 3, t + 33);
    drain();
    send32(1'b0, 32'd12345, 32'd7, 5'd13, 1'b0, t);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", longint'(b32.out_valid), 0);
    chk("midrst_in_ready", longint'(b32.in_ready), 1);
    chk("midrst_quot", longint'(b32.out_quot), 0);
    chk("midrst_rem", longint'(b32.out_rem), 0);
    chk("midrst_tag", longint'(b32.out_tag), 0);
    repeat (40) tick();

    // Narrow-width regression.
    send8(1'b0, 8'd200, 8'd3, 5'd17, 1'b0, t);
    push8(66, 2, 17, t + 9);
    n = 0;
    while (n < 12) begin
      a8  = 8'($urandom);
      b8v = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 1) ? 8'hFF : 8'h00) : 8'($urandom);
      if (n == 0) begin a8 = 8'h80; b8v = 8'hFF; end
      send8(1'($urandom_range(0, 1)) | (n == 0), a8, b8v, 5'($urandom), 1'b1, t);
      n++;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/div_iter_unit.md
# div_iter_unit

Parametrised radix-2 restoring divider for the execute stage, successor to the fixed 32-bit divider. It accepts a signed or unsigned divide with a ready/valid handshake and iterates one quotient bit per cycle. It returns quotient, remainder and a caller-supplied tag, and honours pipeline flush. Divide-by-zero and signed overflow complete in one cycle with RISC-V-defined results.

## Interface
- XLEN, 32: operand/result width, ≥ 2.
- TAG_W, 5: width of the opaque tag carried through (rd index / ROB id).
- clock  in  1  single clock; everything is sampled on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards any op in flight and any op accepted this cycle.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept.
- in_sign  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
- in_a, in_b  in  XLEN  dividend, divisor.
- in_tag  in  TAG_W  tag, returned unchanged.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result valid.
- out_quot, out_rem  out  XLEN  quotient, remainder.
- out_tag  out  TAG_W  tag of this result.

## Operation
- States: IDLE, BUSY, DONE. A counter of width $clog2(XLEN+1) tracks remaining iterations.
- Accept = in_valid & in_ready & ~flush. In IDLE, in_ready = 1. In DONE, in_ready = out_ready. Otherwise in_ready = 0. flush does not gate in_ready; a handshake in a flush cycle is dropped.
- On accept, latch the magnitudes of a and b, with two's-complement negation applied when in_sign and the operand MSB are set. Also latch the quotient sign qs = sign & (a_msb ^ b_msb), the remainder sign rs = sign & a_msb, and the tag.
- Special cases go straight to DONE, skipping BUSY:
  - b == 0: quot = all ones, rem = in_a (raw).
  - in_sign & a == 2^(XLEN-1) & b == all ones: quot = in_a, rem = 0.
- Otherwise the unit enters BUSY with count = XLEN.
- Each BUSY cycle:
  - Form trial = partial_rem[XLEN:0] − {0,b} at XLEN+1 bits.
  - If trial is non-negative, partial_rem takes the trial value and the quotient bit is 1. Otherwise the quotient bit is 0.
  - Shift the dividend left by one and decrement count.
  - When count reaches 1, the next state is DONE.
- Leaving BUSY, the result registers are loaded with final values: quot = qs ? −q : q, rem = rs ? −r : r. Outputs are registered, not combinational from the datapath.
- In DONE, out_valid = 1 and all outputs hold stable until out_ready.
  - out_ready & in_valid: the result retires and the new op is accepted in the same cycle (goes to BUSY or DONE).
  - out_ready alone: the unit goes to IDLE.
- flush in any state: next state is IDLE, out_valid drops next cycle, and a coincident accept is discarded. Result registers are not cleared.
- Reset: state IDLE, in_ready = 1, out_valid = 0, out_quot/out_rem/out_tag = 0.

## Timing
- Normal op accepted in cycle t: out_valid first high in cycle t+XLEN+1 (t+33 for XLEN = 32).
- Special case accepted in cycle t: out_valid high in cycle t+1.
- Throughput is one op per XLEN+1 cycles. With out_ready held high, there are no bubbles between the DONE retire and the next accept.
- Backpressure: the DONE state is held indefinitely, and out_quot/out_rem/out_tag do not change while out_valid & ~out_ready.
- Reset has priority over flush. flush has priority over both handshakes.

## Structure
- Package div_pkg:
  - typedef enum div_state_e {IDLE, BUSY, DONE}.
  - Function cnt_w(XLEN) = $clog2(XLEN+1).
  - Constants for the special-case results.
- Sub-module div_fixup (combinational, parameter XLEN) performs conditional two's-complement negate. It is instantiated for the a and b magnitudes and for the quot and rem sign correction.
- The top level holds the FSM, the counter, the partial remainder/quotient shift registers and the result registers.

## Test plan
- Unsigned 100/7 (XLEN=32), out_ready=1 -> q=14, r=2, out_valid exactly at t+33, tag echoed.
- Signed −7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/−2 -> q=0xFFFFFFFD, r=1.
- Divide by zero, signed 5/0 -> q=0xFFFFFFFF, r=5 at t+1. Signed overflow 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0 at t+1.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> outputs stable, in_ready=0. Then raise out_ready with in_valid=1 -> retire and accept in the same cycle; next result follows 33 cycles later.
- Flush at t+10 of a BUSY op -> out_valid never asserts for that op, in_ready=1 next cycle. Flush coincident with accept -> op dropped.
- Reset asserted mid-BUSY -> next cycle state IDLE, out_valid=0, outputs 0. XLEN=8 regression: 200/3 -> q=66, r=2 at t+9.
